// File: rtl/fp_add_subt_pkg.sv
// rtl/fp_add_subt_pkg.sv - shared constants, state encoding and unpack helper for the fp add/sub unit
package fp_add_subt_pkg;

  localparam int W    = 32;
  localparam int EW   = 8;
  localparam int SW   = 23;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = 2 * BIAS + 1;
  localparam int GRS  = 3;
  localparam int MW   = 1 + SW + GRS;

  localparam logic [W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [W-1:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Working significand with hidden bit and empty G/R/S; zero exponent means flushed zero.
  function automatic logic [MW-1:0] sig_of(input logic [W-2:0] mag);
    return (|mag[W-2:SW]) ? {1'b1, mag[SW-1:0], {GRS{1'b0}}} : '0;
  endfunction

endpackage

// File: rtl/fp_lzd_27.sv
// rtl/fp_lzd_27.sv - leading-zero count of a 27-bit significand (27 when all zero)
module fp_lzd_27 (
  input  logic [26:0] i_sig,
  output logic [4:0]  o_lz
);

  always_comb begin
    o_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_sig[i]) o_lz = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_subt_unit.sv
// rtl/fp_add_subt_unit.sv - multi-cycle single-precision adder/subtractor with beg/ready/ack handshake
module fp_add_subt_unit
  import fp_add_subt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         op_add_subt,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic [W-1:0] result_add_subt,
  output logic         overflow_flag,
  output logic         underflow_flag
);

  localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'(EMAX);

  state_t r_state, w_next;

  logic [W-1:0]         r_x, r_y;
  logic                 r_op;
  logic                 r_sa, r_sb;
  logic [EW-1:0]        r_ea, r_eb;
  logic [MW-1:0]        r_ma, r_mb;
  logic                 r_special;
  logic [W-1:0]         r_special_val;
  logic [MW:0]          r_sum;
  logic [MW-1:0]        r_m;
  logic signed [EW+1:0] r_exp;
  logic                 r_zero;
  logic [W-1:0]         r_result;
  logic                 r_ovf, r_unf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (beg_add_subt) w_next = S_LOAD;
      S_LOAD:  w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (ack_add_subt) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic         w_xs, w_ys, w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_swap;
  logic [W-2:0] w_x_mag, w_y_mag, w_a_mag, w_b_mag;
  logic         w_special;
  logic [W-1:0] w_special_val;

  assign w_xs    = r_x[W-1];
  assign w_ys    = r_y[W-1] ^ r_op;
  assign w_x_nan = (&r_x[W-2:SW]) && (|r_x[SW-1:0]);
  assign w_y_nan = (&r_y[W-2:SW]) && (|r_y[SW-1:0]);
  assign w_x_inf = (&r_x[W-2:SW]) && !(|r_x[SW-1:0]);
  assign w_y_inf = (&r_y[W-2:SW]) && !(|r_y[SW-1:0]);
  assign w_x_mag = (|r_x[W-2:SW]) ? r_x[W-2:0] : '0;
  assign w_y_mag = (|r_y[W-2:SW]) ? r_y[W-2:0] : '0;
  assign w_swap  = w_y_mag > w_x_mag;
  assign w_a_mag = w_swap ? w_y_mag : w_x_mag;
  assign w_b_mag = w_swap ? w_x_mag : w_y_mag;

  always_comb begin
    w_special     = 1'b1;
    w_special_val = QNAN;
    if (w_x_nan || w_y_nan)     w_special_val = QNAN;
    else if (w_x_inf && w_y_inf) w_special_val = (w_xs == w_ys) ? {w_xs, POS_INF[W-2:0]} : QNAN;
    else if (w_x_inf)            w_special_val = {w_xs, POS_INF[W-2:0]};
    else if (w_y_inf)            w_special_val = {w_ys, POS_INF[W-2:0]};
    else                         w_special     = 1'b0;
  end

  // Alignment: bits shifted out below S collapse into S so rounding stays exact.
  logic [EW-1:0] w_de;
  logic [MW-1:0] w_mb_al;

  assign w_de = r_ea - r_eb;

  always_comb begin
    w_mb_al = r_mb >> w_de;
    if (w_de >= EW'(MW))
      w_mb_al = {{(MW-1){1'b0}}, |r_mb};
    else
      w_mb_al[0] = w_mb_al[0] | (|(r_mb & ~({MW{1'b1}} << w_de)));
  end

  logic [4:0]           w_lz;
  logic [MW-1:0]        w_m_n;
  logic signed [EW+1:0] w_exp_n;

  fp_lzd_27 u_lzd (
    .i_sig (r_sum[MW-1:0]),
    .o_lz  (w_lz)
  );

  always_comb begin
    if (r_sum[MW]) begin
      w_m_n   = {r_sum[MW:2], |r_sum[1:0]};
      w_exp_n = {2'b00, r_ea} + (EW+2)'(1);
    end else begin
      w_m_n   = r_sum[MW-1:0] << w_lz;
      w_exp_n = {2'b00, r_ea} - {{(EW-3){1'b0}}, w_lz};
    end
  end

  logic                 w_round_up, w_sign, w_ovf, w_unf;
  logic [SW+1:0]        w_mant;
  logic signed [EW+1:0] w_exp_r;
  logic [SW-1:0]        w_frac_r;
  logic [W-1:0]         w_res;

  assign w_round_up = r_m[GRS-1] & (r_m[GRS-2] | r_m[0] | r_m[GRS]);
  assign w_mant     = {1'b0, r_m[MW-1:GRS]} + {{(SW+1){1'b0}}, w_round_up};
  assign w_exp_r    = r_exp + {{(EW+1){1'b0}}, w_mant[SW+1]};
  assign w_frac_r   = w_mant[SW+1] ? w_mant[SW:1] : w_mant[SW-1:0];
  assign w_sign     = r_zero ? (r_sa & r_sb) : r_sa;

  always_comb begin
    w_res = {w_sign, w_exp_r[EW-1:0], w_frac_r};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_special) begin
      w_res = r_special_val;
    end else if (r_zero) begin
      w_res = {w_sign, {(W-1){1'b0}}};
    end else if (w_exp_r >= EXP_MAX) begin
      w_res = {w_sign, POS_INF[W-2:0]};
      w_ovf = 1'b1;
    end else if (w_exp_r[EW+1] || (w_exp_r == '0)) begin
      w_res = {w_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_op          <= 1'b0;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_ea          <= '0;
      r_eb          <= '0;
      r_ma          <= '0;
      r_mb          <= '0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_sum         <= '0;
      r_m           <= '0;
      r_exp         <= '0;
      r_zero        <= 1'b0;
      r_result      <= '0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (beg_add_subt) begin
            r_x  <= Data_X;
            r_y  <= Data_Y;
            r_op <= op_add_subt;
          end
        end
        S_LOAD: begin
          r_sa          <= w_swap ? w_ys : w_xs;
          r_sb          <= w_swap ? w_xs : w_ys;
          r_ea          <= w_a_mag[W-2:SW];
          r_eb          <= w_b_mag[W-2:SW];
          r_ma          <= sig_of(w_a_mag);
          r_mb          <= sig_of(w_b_mag);
          r_special     <= w_special;
          r_special_val <= w_special_val;
        end
        S_ALIGN: r_mb <= w_mb_al;
        S_ADD: begin
          r_sum <= (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                  : ({1'b0, r_ma} - {1'b0, r_mb});
        end
        S_NORM: begin
          r_m    <= w_m_n;
          r_exp  <= w_exp_n;
          r_zero <= (r_sum == '0);
        end
        S_ROUND: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
        end
        default: ;
      endcase
    end
  end

  assign ready_add_subt  = (r_state == S_DONE);
  assign result_add_subt = r_result;
  assign overflow_flag   = r_ovf;
  assign underflow_flag  = r_unf;

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// tb/tb_fp_add_subt_unit.sv - self-checking bench for fp_add_subt_unit
module tb_fp_add_subt_unit;

  logic        clk = 1'b0;
  logic        reset, beg_add_subt, ack_add_subt, op_add_subt;
  logic [31:0] Data_X, Data_Y;
  logic        ready_add_subt, overflow_flag, underflow_flag;
  logic [31:0] result_add_subt;

  fp_add_subt_unit dut (
    .clk             (clk),
    .reset           (reset),
    .beg_add_subt    (beg_add_subt),
    .ack_add_subt    (ack_add_subt),
    .op_add_subt     (op_add_subt),
    .Data_X          (Data_X),
    .Data_Y          (Data_Y),
    .ready_add_subt  (ready_add_subt),
    .result_add_subt (result_add_subt),
    .overflow_flag   (overflow_flag),
    .underflow_flag  (underflow_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_valid = 1'b0;
  logic [31:0] exp_res   = '0;
  logic        exp_ovf   = 1'b0;
  logic        exp_unf   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Exact arithmetic on a fixed-point grid of 2^-149, then round-to-nearest-even to 24 bits.
  // Returns {overflow, underflow, result}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic op);
    logic [287:0] ma, mb, mag, q, rem, half;
    logic [7:0]   xe, ye;
    logic         sa, sb, s, x_nan, y_nan, x_inf, y_inf;
    int           p, sh, be;
    xe = x[30:23];
    ye = y[30:23];
    sa = x[31];
    sb = y[31] ^ op;
    x_nan = (xe == 8'hFF) && (x[22:0] != 0);
    y_nan = (ye == 8'hFF) && (y[22:0] != 0);
    x_inf = (xe == 8'hFF) && (x[22:0] == 0);
    y_inf = (ye == 8'hFF) && (y[22:0] == 0);
    if (x_nan || y_nan) return {2'b00, 32'h7FC00000};
    if (x_inf && y_inf) return (sa == sb) ? {2'b00, sa, 31'h7F800000} : {2'b00, 32'h7FC00000};
    if (x_inf) return {2'b00, sa, 31'h7F800000};
    if (y_inf) return {2'b00, sb, 31'h7F800000};
    ma = '0;
    mb = '0;
    if (xe != 0) ma = 288'({1'b1, x[22:0]}) << (int'(xe) - 1);
    if (ye != 0) mb = 288'({1'b1, y[22:0]}) << (int'(ye) - 1);
    if (sa == sb) begin
      mag = ma + mb; s = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; s = sa;
    end else begin
      mag = mb - ma; s = sb;
    end
    if (mag == 0) return {2'b00, sa & sb, 31'b0};
    p = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    be = p - 22;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((288'd1 << sh) - 288'd1);
      half = 288'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 288'd1;
    end else begin
      q = mag << (23 - p);
    end
    if (q[24]) begin
      q = q >> 1;
      be++;
    end
    if (be >= 255) return {2'b10, s, 31'h7F800000};
    if (be <= 0)   return {2'b01, s, 31'b0};
    return {2'b00, s, 8'(be), q[22:0]};
  endfunction

  always @(negedge clk) begin
    if (ready_add_subt) begin
      check("dut_vs_model", {29'b0, exp_valid, overflow_flag, underflow_flag, result_add_subt},
                            {29'b0, 1'b1, exp_ovf, exp_unf, exp_res});
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic o,
                       input int hold, input bit poke);
    logic [33:0] m;
    bit          quiet;
    m = model(x, y, o);
    @(negedge clk);
    Data_X = x; Data_Y = y; op_add_subt = o; beg_add_subt = 1'b1;
    exp_res = m[31:0]; exp_ovf = m[33]; exp_unf = m[32]; exp_valid = 1'b1;
    @(posedge clk); #1;
    beg_add_subt = 1'b0;
    Data_X = ~x; Data_Y = ~y; op_add_subt = ~o;
    quiet = !ready_add_subt;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ready_add_subt) quiet = 1'b0;
    end
    check("ready_low_k_to_k4", 64'(quiet), 64'd1);
    @(posedge clk); #1;
    check("ready_after_k5", 64'(ready_add_subt), 64'd1);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 3) beg_add_subt = 1'b1;
      @(posedge clk); #1;
      beg_add_subt = 1'b0;
    end
    check("ready_hold", 64'(ready_add_subt), 64'd1);
    ack_add_subt = 1'b1;
    if (poke) beg_add_subt = 1'b1;
    @(posedge clk); #1;
    ack_add_subt = 1'b0;
    beg_add_subt = 1'b0;
    check("ready_clear_on_ack", 64'(ready_add_subt), 64'd0);
    check("result_held_idle", 64'(result_add_subt), 64'(m[31:0]));
    exp_valid = 1'b0;
    if (poke) begin
      quiet = 1'b1;
      repeat (6) begin
        @(posedge clk); #1;
        if (ready_add_subt) quiet = 1'b0;
      end
      check("beg_with_ack_ignored", 64'(quiet), 64'd1);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] x, input logic [31:0] y, input logic op,
                         input logic [33:0] e);
    vec_t v;
    v.x = x; v.y = y; v.op = op; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    bit quiet;
    reset = 1'b0; beg_add_subt = 1'b0; ack_add_subt = 1'b0; op_add_subt = 1'b0;
    Data_X = '0; Data_Y = '0;

    add_vec(32'h3F800000, 32'h3F800000, 1'b0, {2'b00, 32'h40000000});
    add_vec(32'h3FC00000, 32'h3E800000, 1'b1, {2'b00, 32'h3FA00000});
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, {2'b00, 32'h00000000});
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {2'b10, 32'h7F800000});
    add_vec(32'h7F800000, 32'h7F800000, 1'b1, {2'b00, 32'h7FC00000});
    add_vec(32'h3F800000, 32'h33800000, 1'b0, {2'b00, 32'h3F800000});
    add_vec(32'h3F800001, 32'h33800000, 1'b0, {2'b00, 32'h3F800002});
    add_vec(32'h80000000, 32'h80000000, 1'b0, {2'b00, 32'h80000000});
    add_vec(32'h7F800000, 32'h3F800000, 1'b0, {2'b00, 32'h7F800000});
    add_vec(32'h3F800000, 32'hFF800000, 1'b1, {2'b00, 32'h7F800000});
    add_vec(32'h7FC00001, 32'h3F800000, 1'b0, {2'b00, 32'h7FC00000});
    add_vec(32'h00800001, 32'h00800000, 1'b1, {2'b01, 32'h00000000});
    add_vec(32'h00400000, 32'h3F800000, 1'b0, {2'b00, 32'h3F800000});
    add_vec(32'hC0200000, 32'h3F800000, 1'b0, {2'b00, 32'hBFC00000});
    add_vec(32'h3F800000, 32'h3FC00000, 1'b1, {2'b00, 32'hBF000000});
    add_vec(32'h4B800000, 32'h3F800000, 1'b0, {2'b00, 32'h4B800000});
    add_vec(32'h4B800000, 32'h40400000, 1'b0, {2'b00, 32'h4B800002});
    add_vec(32'h3F800000, 32'h30800000, 1'b1, {2'b00, 32'h3F800000});

    #12;
    check("reset_outputs", {29'b0, ready_add_subt, overflow_flag, underflow_flag, result_add_subt},
                           64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      check("model_pin", 64'(model(vecs[i].x, vecs[i].y, vecs[i].op)), 64'(vecs[i].exp));
      do_op(vecs[i].x, vecs[i].y, vecs[i].op, 0, 1'b0);
    end

    do_op(32'h3FC00000, 32'h3E800000, 1'b1, 10, 1'b1);
    do_op(32'h40000000, 32'h3F800000, 1'b0, 2, 1'b0);

    @(negedge clk);
    Data_X = 32'h3F800000; Data_Y = 32'h3F800000; op_add_subt = 1'b0; beg_add_subt = 1'b1;
    @(posedge clk); #1;
    beg_add_subt = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_reset_in_align",
          {29'b0, ready_add_subt, overflow_flag, underflow_flag, result_add_subt}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_add_subt) quiet = 1'b0;
    end
    check("no_ready_after_reset", 64'(quiet), 64'd1);
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
